// File: rtl/word56_reader_pkg.sv
// Shared constants and state encoding for the 56-bit word to byte reader.
package word56_reader_pkg;

  localparam int WORD_W         = 56;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 7;
  localparam int CNT_W          = 3;

  // Index of the final byte of a word (drives out_last).
  localparam logic [CNT_W-1:0] LAST_IDX = 3'(BYTES_PER_WORD - 1);

  // Reader FSM encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_WAIT = 2'd2;
  localparam state_t ST_SEND = 2'd3;

endpackage

// File: rtl/word56_shift_unit.sv
// Holds the fetched 56-bit word and presents one byte at a time.
// MSB_FIRST=1 presents [55:48] first and shifts left; MSB_FIRST=0
// presents [7:0] first and shifts right. Vacated bits fill with zero,
// so the register is all-zero once a whole word has been consumed.
module word56_shift_unit
  import word56_reader_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] load_data,
  output logic [BYTE_W-1:0] byte_out
);

  logic [WORD_W-1:0] sr;

  // Load a new word or advance by one byte; load wins over shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= load_data;
    end else if (shift) begin
      if (MSB_FIRST) begin
        sr <= {sr[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
      end else begin
        sr <= {{BYTE_W{1'b0}}, sr[WORD_W-1:BYTE_W]};
      end
    end
  end

  assign byte_out = MSB_FIRST ? sr[WORD_W-1 -: BYTE_W] : sr[BYTE_W-1:0];

endmodule

// File: rtl/word56_byte_reader.sv
// Pops 56-bit words from a FIFO and streams them out as seven bytes.
// Optional feature: define WORD56_READER_PARITY_EN to add out_parity.
//
// Output handshake: a byte transfers on a rising clk edge where
// out_valid && out_ready. Once out_valid is high, out_data, out_valid
// and out_last stay stable until that transfer happens; out_valid never
// depends combinationally on out_ready.
//
// FIFO side: rd_en is a registered one-cycle pop; rd_data is captured
// one cycle later (end of WAIT), so the first byte appears two cycles
// after the rd_en cycle.
module word56_byte_reader
  import word56_reader_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [WORD_W-1:0] rd_data,
  output logic              rd_en,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
`ifdef WORD56_READER_PARITY_EN
  output logic              out_parity,
`endif
  output state_t            dbg_state
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] byte_cnt;
  logic             start;
  logic             handshake;
  logic             last_hs;

  // fifo_empty and enable only matter while idle.
  assign start     = (state == ST_IDLE) && enable && !fifo_empty;
  assign handshake = out_valid && out_ready;
  assign last_hs   = handshake && (byte_cnt == LAST_IDX);

  // Next-state decode: fetch, wait for data, then stream seven bytes.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_REQ;
      ST_REQ:  state_nxt = ST_WAIT;
      ST_WAIT: state_nxt = ST_SEND;
      ST_SEND: if (last_hs) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // rd_en is high exactly for the cycle spent in REQ.
  always_ff @(posedge clk) begin
    if (reset) rd_en <= 1'b0;
    else       rd_en <= start;
  end

  // Byte counter: 0..6 within a word, cleared after the last transfer.
  always_ff @(posedge clk) begin
    if (reset || last_hs) byte_cnt <= '0;
    else if (handshake)   byte_cnt <= byte_cnt + 3'd1;
  end

  word56_shift_unit #(
    .MSB_FIRST(MSB_FIRST)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .load     (state == ST_WAIT),
    .shift    (handshake),
    .load_data(rd_data),
    .byte_out (out_data)
  );

  assign out_valid = (state == ST_SEND);
  assign out_last  = out_valid && (byte_cnt == LAST_IDX);
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

`ifdef WORD56_READER_PARITY_EN
  // Odd parity: the nine bits {out_data, out_parity} hold an odd number of ones.
  assign out_parity = ~^out_data;
`endif

endmodule

// File: tb/tb_word56_byte_reader.sv
// Bench for word56_byte_reader: one MSB-first and one LSB-first instance
// share a behavioural FIFO and the same stimulus.
`timescale 1ns/1ps
module tb_word56_byte_reader;
  import word56_reader_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        out_ready = 1'b0;
  logic        fifo_empty;
  logic [55:0] rd_data = '0;

  logic        rd_en_m, valid_m, last_m, busy_m;
  logic        rd_en_l, valid_l, last_l, busy_l;
  logic [7:0]  data_m, data_l;
  state_t      st_m, st_l;
`ifdef WORD56_READER_PARITY_EN
  logic        par_m, par_l;
`endif

  always #5 clk = ~clk;

  word56_byte_reader #(.MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .rd_data(rd_data), .rd_en(rd_en_m), .out_data(data_m), .out_valid(valid_m),
    .out_ready(out_ready), .out_last(last_m), .busy(busy_m),
`ifdef WORD56_READER_PARITY_EN
    .out_parity(par_m),
`endif
    .dbg_state(st_m)
  );

  word56_byte_reader #(.MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .rd_data(rd_data), .rd_en(rd_en_l), .out_data(data_l), .out_valid(valid_l),
    .out_ready(out_ready), .out_last(last_l), .busy(busy_l),
`ifdef WORD56_READER_PARITY_EN
    .out_parity(par_l),
`endif
    .dbg_state(st_l)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- FIFO model ----------------
  logic [55:0] fifo_q[$];
  int          push_cnt = 0;
  int          pop_cnt = 0;
  logic [55:0] pop_word;
  assign fifo_empty = (push_cnt == pop_cnt);

  // Reference: each popped word becomes seven {last, byte} entries per order.
  logic [8:0] exp_q_m[$];
  logic [8:0] exp_q_l[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en_m && fifo_q.size() > 0) begin
      pop_word = fifo_q.pop_front();
      rd_data <= pop_word;
      pop_cnt <= pop_cnt + 1;
      if (!reset) begin
        for (int k = 0; k < 7; k++) begin
          exp_q_m.push_back({k == 6, 8'(pop_word >> (8 * (6 - k)))});
          exp_q_l.push_back({k == 6, 8'(pop_word >> (8 * k))});
        end
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [7:0] got_m[$];
  logic [7:0] got_l[$];
  int         hs_cyc[$];
  int         rd_cycles[$];
  logic       prev_valid[2];
  logic       prev_last[2];
  logic [7:0] prev_data[2];
  logic       prev_start[2];
  int         rd_cyc[2];
  logic       prev_ready = 1'b0;
  logic       prev_reset = 1'b1;

  initial begin
    for (int d = 0; d < 2; d++) begin
      prev_valid[d] = 1'b0; prev_last[d] = 1'b0; prev_data[d] = '0;
      prev_start[d] = 1'b0; rd_cyc[d] = -100;
    end
  end

  function automatic bit pop_exp(input int d, output logic [8:0] e);
    e = '0;
    if (d == 0) begin
      if (exp_q_m.size() == 0) return 1'b0;
      e = exp_q_m.pop_front();
    end else begin
      if (exp_q_l.size() == 0) return 1'b0;
      e = exp_q_l.pop_front();
    end
    return 1'b1;
  endfunction

  task automatic mon_port(input int d, input logic rd_en, input logic valid,
                          input logic [7:0] data, input logic last, input logic busy);
    logic [8:0] e;
    string tag;
    tag = (d == 0) ? "msb" : "lsb";
    // rd_en must follow exactly one cycle after an idle, enabled, non-empty cycle.
    check({tag, "_rd_en"}, 64'(rd_en), 64'(prev_start[d]));
    if (rd_en) begin
      rd_cyc[d] = cyc;
      if (d == 0) rd_cycles.push_back(cyc);
    end
    if (valid && !prev_valid[d]) check({tag, "_first_latency"}, 64'(cyc - rd_cyc[d]), 64'd2);
    if (prev_valid[d] && !prev_ready && !prev_reset) begin
      check({tag, "_stall_valid"}, 64'(valid), 64'd1);
      check({tag, "_stall_data"}, 64'(data), 64'(prev_data[d]));
      check({tag, "_stall_last"}, 64'(last), 64'(prev_last[d]));
    end
    if (valid && out_ready && !reset) begin
      if (pop_exp(d, e)) begin
        check({tag, "_byte"}, 64'(data), 64'(e[7:0]));
        check({tag, "_last"}, 64'(last), 64'(e[8]));
`ifdef WORD56_READER_PARITY_EN
        check({tag, "_parity"}, 64'((d == 0) ? par_m : par_l), 64'(~^e[7:0]));
`endif
        if (d == 0) begin
          got_m.push_back(data);
          hs_cyc.push_back(cyc);
        end else begin
          got_l.push_back(data);
        end
      end else begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected_byte: got %0h expected none (cycle %0d)", tag, data, cyc);
      end
    end
    if (reset) begin
      if (d == 0) exp_q_m.delete();
      else        exp_q_l.delete();
    end
    prev_valid[d] = valid;
    prev_data[d]  = data;
    prev_last[d]  = last;
    prev_start[d] = !reset && !busy && enable && !fifo_empty;
  endtask

  always @(negedge clk) begin
    mon_port(0, rd_en_m, valid_m, data_m, last_m, busy_m);
    mon_port(1, rd_en_l, valid_l, data_l, last_l, busy_l);
    prev_ready = out_ready;
    prev_reset = reset;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [55:0] w);
    fifo_q.push_back(w);
    push_cnt++;
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_valid_m"}, 64'(valid_m), 64'd0);
    check({name, "_valid_l"}, 64'(valid_l), 64'd0);
    check({name, "_last_m"}, 64'(last_m), 64'd0);
    check({name, "_busy_m"}, 64'(busy_m), 64'd0);
    check({name, "_busy_l"}, 64'(busy_l), 64'd0);
    check({name, "_rd_en_m"}, 64'(rd_en_m), 64'd0);
    check({name, "_data_m"}, 64'(data_m), 64'h00);
    check({name, "_data_l"}, 64'(data_l), 64'h00);
    check({name, "_state_m"}, 64'(st_m), 64'(ST_IDLE));
`ifdef WORD56_READER_PARITY_EN
    check({name, "_parity_m"}, 64'(par_m), 64'd1);
`endif
  endtask

  task automatic wait_drained(input string name, input int budget);
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || exp_q_m.size() != 0 || exp_q_l.size() != 0 ||
            busy_m || busy_l) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drain_timeout"}, 64'(n < budget), 64'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [55:0] word;
    logic [7:0]  ready_pat;  // bit (n % 8) drives out_ready on cycle n
    logic [55:0] exp_m;      // emission order, first byte in [55:48]
    logic [55:0] exp_l;
    int          span;       // cycles first->last byte, 0 = not checked
  } vec_t;

  vec_t vt[4];

  initial begin
    int n;
    logic [55:0] w;

    vt[0] = '{56'h0123456789ABCD, 8'hFF,       56'h0123456789ABCD, 56'hCDAB8967452301, 6};
    vt[1] = '{56'h0123456789ABCD, 8'b10011001, 56'h0123456789ABCD, 56'hCDAB8967452301, 0};
    vt[2] = '{56'h0103FF00A55A80, 8'hFF,       56'h0103FF00A55A80, 56'h805AA500FF0301, 6};
    vt[3] = '{56'hFEDCBA98765432, 8'b01010101, 56'hFEDCBA98765432, 56'h32547698BADCFE, 0};

    // Reset state.
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Table-driven words.
    for (int i = 0; i < 4; i++) begin
      tick();
      got_m.delete(); got_l.delete(); hs_cyc.delete();
      push_word(vt[i].word);
      enable = 1'b1;
      n = 0;
      while ((got_m.size() < 7 || got_l.size() < 7) && n < 80) begin
        out_ready = vt[i].ready_pat[n % 8];
        tick();
        n++;
      end
      check("vec_count_m", 64'(got_m.size()), 64'd7);
      check("vec_count_l", 64'(got_l.size()), 64'd7);
      for (int k = 0; k < 7; k++) begin
        if (got_m.size() > k) check("vec_byte_m", 64'(got_m[k]), 64'(vt[i].exp_m[55 - 8 * k -: 8]));
        if (got_l.size() > k) check("vec_byte_l", 64'(got_l[k]), 64'(vt[i].exp_l[55 - 8 * k -: 8]));
      end
      if (vt[i].span != 0 && hs_cyc.size() == 7)
        check("vec_consecutive", 64'(hs_cyc[6] - hs_cyc[0]), 64'(vt[i].span));
      tick();
      @(negedge clk);
      check("vec_back_idle", 64'(busy_m), 64'd0);
    end

    // Back-to-back words: REQ to REQ is 10 cycles with out_ready held high.
    tick();
    rd_cycles.delete();
    out_ready = 1'b1;
    push_word(56'h11223344556677);
    push_word(56'h8899AABBCCDDEE);
    enable = 1'b1;
    wait_drained("b2b", 100);
    check("b2b_count", 64'(rd_cycles.size()), 64'd2);
    if (rd_cycles.size() == 2) check("b2b_period", 64'(rd_cycles[1] - rd_cycles[0]), 64'd10);

    // Empty FIFO with enable high: no fetch, never busy.
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      @(negedge clk);
      check("empty_rd_en", 64'(rd_en_m | rd_en_l), 64'd0);
      check("empty_busy", 64'(busy_m | busy_l), 64'd0);
    end

    // Reset after the third byte discards the rest of the word.
    tick();
    got_m.delete(); got_l.delete();
    out_ready = 1'b1;
    push_word(56'h0123456789ABCD);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    n = 0;
    while (got_m.size() < 3 && n < 40) begin
      tick();
      n++;
    end
    check("rst_mid_reach", 64'(got_m.size()), 64'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst_mid");
    repeat (3) tick();
    check("rst_mid_no_more_m", 64'(got_m.size()), 64'd3);
    check("rst_mid_no_more_l", 64'(got_l.size()), 64'd3);
    got_m.delete(); got_l.delete();
    push_word(56'h0123456789ABCD);
    enable = 1'b1;
    wait_drained("rst_fresh", 60);
    check("rst_fresh_count", 64'(got_m.size()), 64'd7);
    if (got_m.size() > 0) check("rst_fresh_first_m", 64'(got_m[0]), 64'h01);
    if (got_l.size() > 0) check("rst_fresh_first_l", 64'(got_l[0]), 64'hCD);

    // Randomised traffic against the reference queues.
    n = 0;
    for (int i = 0; i < 700; i++) begin
      enable    = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if (n < 30 && fifo_q.size() < 8 && $urandom_range(0, 5) == 0) begin
        w[55:32] = 24'($urandom_range(0, 24'hFFFFFF));
        w[31:0]  = $urandom();
        push_word(w);
        n++;
      end
      tick();
    end
    enable = 1'b1;
    out_ready = 1'b1;
    wait_drained("rand", 600);
    check("rand_exp_empty_m", 64'(exp_q_m.size()), 64'd0);
    check("rand_exp_empty_l", 64'(exp_q_l.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (checks %0d errors %0d)", checks, errors);
    $fatal(1);
  end

endmodule
